bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter feeding the four-digit seven-segment display path. It captures a binary word, typically the 16 switch inputs, on a start pulse. It converts the word with an iterative shift-and-add-3 (double-dabble) datapath at one bit per clock. It then presents a registered packed-BCD result with a one-cycle done pulse and an overflow flag to the downstream digit multiplexer/decoder.

---
 rtl/bin_to_bcd_seq_if.sv | 29 ++
 rtl/bin_to_bcd_seq.sv | 119 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bin_to_bcd_seq_if : start/operand and BCD result bundle               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+

interface bin_to_bcd_seq_if #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_DIGITS = 4
);
  logic                    start;
  logic [IN_WIDTH-1:0]     bin_in;
  logic                    busy;
  logic                    done;
  logic [4*OUT_DIGITS-1:0] bcd_out;
  logic                    overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bin_to_bcd_seq : one-bit-per-clock double-dabble binary to BCD        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+

module bin_to_bcd_seq #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus
);

  // Digits needed for 2^IN_WIDTH-1 is floor(IN_WIDTH*log10(2))+1.
  localparam int c_RAW_DIGITS = (IN_WIDTH * 30103) / 100000 + 1;
  localparam int c_BCD_DIGITS = (c_RAW_DIGITS > OUT_DIGITS) ? c_RAW_DIGITS : OUT_DIGITS;
  localparam int c_ACC_W      = 4 * c_BCD_DIGITS;
  localparam int c_OUT_W      = 4 * OUT_DIGITS;
  localparam int c_CNT_W      = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(IN_WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [c_CNT_W-1:0]     cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]    sh_q, sh_d;
  logic [c_ACC_W-1:0]     acc_q, acc_d;
  logic [c_OUT_W-1:0]     bcd_q, bcd_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [c_ACC_W-1:0]          w_adj;
  logic [c_ACC_W+IN_WIDTH-1:0] w_all;
  logic                        w_ovf;

  for (genvar g = 0; g < c_BCD_DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (acc_q[4*g +: 4] >= 4'd5) ? acc_q[4*g +: 4] + 4'd3
                                                        : acc_q[4*g +: 4];
  end

  assign w_all = {w_adj, sh_q} << 1;

  if (c_ACC_W > c_OUT_W) begin : g_ovf
    assign w_ovf = |w_all[c_ACC_W+IN_WIDTH-1:c_OUT_W+IN_WIDTH];
  end else begin : g_no_ovf
    assign w_ovf = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = w_all[c_ACC_W+IN_WIDTH-1:IN_WIDTH];
        sh_d  = w_all[IN_WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_LAST) begin
          bcd_d   = w_all[c_OUT_W+IN_WIDTH-1:IN_WIDTH];
          ovf_d   = w_ovf;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bin_to_bcd_seq : randomized checks against a decimal-digit model   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+

module tb_bin_to_bcd_seq;
  localparam int IW = 16;
  localparam int OD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.IN_WIDTH(IW), .OUT_DIGITS(OD)) bus ();

  bin_to_bcd_seq #(.IN_WIDTH(IW), .OUT_DIGITS(OD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Returns {overflow, low four decimal digits} using plain division.
  function automatic logic [16:0] model(input logic [15:0] v);
    int unsigned x;
    logic [15:0] b;
    x = v;
    b = '0;
    for (int d = 0; d < 4; d++) begin
      b[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {(v >= 16'd10000), b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [15:0] v);
    bus.bin_in = v;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy === 1'b1) busy_cyc++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.bcd_out !== 16'h0000) begin n_bad++; $display("FAIL reset_bcd: got %h expected 0000", bus.bcd_out); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int c, b;
    start_conv(16'h270F);
    wait_done(c, b);
    n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL basic_latency: got %0d expected 16", c); end
    n_cmp++; if (b !== 16) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d expected 16", b); end
    n_cmp++; if (bus.bcd_out !== 16'h9999) begin n_bad++; $display("FAIL basic_bcd: got %h expected 9999", bus.bcd_out); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b expected 0", bus.overflow); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b expected 0", bus.busy); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
  endtask

  // Each new start is issued in the done cycle of the previous conversion.
  task automatic run_chain(input string name, input logic [15:0] vals[$]);
    int c, b;
    logic [16:0] exp;
    start_conv(vals[0]);
    for (int i = 0; i < vals.size(); i++) begin
      wait_done(c, b);
      exp = model(vals[i]);
      n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL %s_latency[%0d]: got %0d expected 16", name, i, c); end
      n_cmp++; if (bus.bcd_out !== exp[15:0]) begin n_bad++; $display("FAIL %s_bcd[%0d] in=%h: got %h expected %h", name, i, vals[i], bus.bcd_out, exp[15:0]); end
      n_cmp++; if (bus.overflow !== exp[16]) begin n_bad++; $display("FAIL %s_ovf[%0d] in=%h: got %b expected %b", name, i, vals[i], bus.overflow, exp[16]); end
      if (i + 1 < vals.size()) start_conv(vals[i+1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v[$];
    v = '{16'h0001, 16'h0010, 16'h03F2, 16'h270E};
    run_chain("b2b", v);
  endtask

  task automatic test_overflow();
    logic [15:0] v[$];
    v = '{16'h2710, 16'hFFFF, 16'h0000, 16'h270F, 16'h2710};
    run_chain("ovf", v);
  endtask

  task automatic test_random();
    logic [15:0] v[$];
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) v.push_back(16'($urandom_range(9990, 10010)));
      else            v.push_back(16'($urandom_range(0, 65535)));
    end
    run_chain("rand", v);
  endtask

  task automatic test_ignored();
    int n_done = 0;
    int first_k = -1;
    logic [15:0] bcd_at = '0;
    logic        ovf_at = 1'b1;
    start_conv(16'h270F);
    for (int k = 1; k <= 40; k++) begin
      if (k == 3 || k == 10) begin
        bus.start  = 1'b1;
        bus.bin_in = 16'h0001;
      end
      tick();
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_k < 0) begin
          first_k = k;
          bcd_at  = bus.bcd_out;
          ovf_at  = bus.overflow;
        end
      end
    end
    n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL ign_done_count: got %0d expected 1", n_done); end
    n_cmp++; if (first_k !== 16) begin n_bad++; $display("FAIL ign_latency: got %0d expected 16", first_k); end
    n_cmp++; if (bcd_at !== 16'h9999) begin n_bad++; $display("FAIL ign_bcd: got %h expected 9999", bcd_at); end
    n_cmp++; if (ovf_at !== 1'b0) begin n_bad++; $display("FAIL ign_ovf: got %b expected 0", ovf_at); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    int c, b;
    logic [15:0] v;
    logic [16:0] exp;
    start_conv(16'($urandom_range(1, 65535)));
    repeat (7) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.bcd_out !== 16'h0000) begin n_bad++; $display("FAIL rmid_bcd: got %h expected 0000", bus.bcd_out); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf: got %b expected 0", bus.overflow); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b expected 0", bus.done); end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.done === 1'b1) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d expected 0", n_done); end
    v = 16'($urandom_range(0, 65535));
    exp = model(v);
    start_conv(v);
    wait_done(c, b);
    n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL rmid_new_latency: got %0d expected 16", c); end
    n_cmp++; if (bus.bcd_out !== exp[15:0]) begin n_bad++; $display("FAIL rmid_new_bcd in=%h: got %h expected %h", v, bus.bcd_out, exp[15:0]); end
    n_cmp++; if (bus.overflow !== exp[16]) begin n_bad++; $display("FAIL rmid_new_ovf in=%h: got %b expected %b", v, bus.overflow, exp[16]); end
  endtask

  task automatic test_idle_hold();
    int c, b;
    logic [15:0] v;
    logic [16:0] exp;
    v = 16'($urandom_range(10000, 65535));
    exp = model(v);
    start_conv(v);
    wait_done(c, b);
    n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL hold_latency: got %0d expected 16", c); end
    for (int k = 0; k < 50; k++) begin
      tick();
      n_cmp++;
      if (bus.done !== 1'b0 || bus.bcd_out !== exp[15:0] || bus.overflow !== exp[16]) begin
        n_bad++;
        $display("FAIL hold[%0d] in=%h: got done=%b bcd=%h ovf=%b expected done=0 bcd=%h ovf=%b",
                 k, v, bus.done, bus.bcd_out, bus.overflow, exp[15:0], exp[16]);
      end
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_ignored();
    test_reset_mid();
    test_random();
    test_idle_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
